// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the transmitter imports the same encodings.
package uart_rx_pkg;

   // Oversampling ticks per bit period.
   localparam int OS_RATE = 16;

   // Tick count at which the start bit is re-checked (middle of the bit).
   localparam int MID_BIT = 7;

   // Receiver/transmitter state encoding.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } uart_state_e;

   // Tick counter width: 4 bits minimum, wider when the stop period needs it.
   function automatic int tick_cnt_width(input int sb_ticks);
      int w;
      w = $clog2(sb_ticks);
      if (w < 4) begin
         w = 4;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
// Latency: 2 clk from a change on d to the same value on q.
// Backpressure: none; continuously samples.
module uart_rx_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values are simply the previous stage.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Both stages reset to the line's idle level so reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop decode, LSB first, with break hold-off.
// Latency: strobe 8+16*DBITS+SB_TICKS os_ticks after the start edge, plus 2-3 clk skew.
// Backpressure: none; dout holds the last good word, strobes are single-cycle pulses.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DBITS    = 8,
   parameter int SB_TICKS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic             os_tick,
   output logic [DBITS-1:0] dout,
   output logic             rx_done_tick,
   output logic             frame_err
);

   localparam int SW = tick_cnt_width(SB_TICKS);

   localparam logic [SW-1:0] S_MID       = SW'(MID_BIT);
   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OS_RATE - 1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICKS - 1);
   localparam logic [2:0]    N_LAST      = 3'(DBITS - 1);

   logic rx_s;

   uart_state_e      state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [2:0]       n_q, n_d;
   logic [DBITS-1:0] b_q, b_d;
   logic [DBITS-1:0] dout_q, dout_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;

   uart_rx_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Next-state and datapath: counters only advance on os_tick outside IDLE/BRK.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Falling edge seen; no tick needed to leave idle.
            if (!rx_s) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end

         ST_START: begin
            if (os_tick) begin
               if (s_q == S_MID) begin
                  // Re-check in the middle of the start bit to reject glitches.
                  if (!rx_s) begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (os_tick) begin
               if (s_q == S_BIT_LAST) begin
                  // One full bit after the previous mid-bit sample: mid of this bit.
                  s_d = '0;
                  b_d = {rx_s, b_q[DBITS-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         ST_STOP: begin
            if (os_tick) begin
               if (s_q == S_STOP_LAST) begin
                  if (rx_s) begin
                     dout_d  = b_q;
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     // Stop bit low: report once, then wait out the low line.
                     ferr_d  = 1'b1;
                     state_d = ST_BRK;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         ST_BRK: begin
            // Hold off until the line returns high so a break is not decoded as 0x00s.
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames vs a frame-level model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx2;
   logic       os_tick = 1'b0;
   logic       tick_en;
   logic [7:0] dout;
   logic [6:0] dout2;
   logic       done, ferr, done2, ferr2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Monitor-side records (written only by the monitor process).
   logic [7:0] got_q[$];
   logic [7:0] got2_q[$];
   int ferr_cnt = 0;
   int ferr2_cnt = 0;
   int both_cnt = 0;
   int last_done_cyc = 0;

   // Model-side records (written only by the stimulus process).
   logic [7:0] exp_q[$];
   logic [7:0] exp2_q[$];
   logic [7:0] exp_dout;
   logic [7:0] exp_dout2;
   int idx1 = 0;
   int idx2 = 0;

   uart_rx #(.DBITS(8), .SB_TICKS(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .os_tick      (os_tick),
      .dout         (dout),
      .rx_done_tick (done),
      .frame_err    (ferr)
   );

   uart_rx #(.DBITS(7), .SB_TICKS(32)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx2),
      .os_tick      (os_tick),
      .dout         (dout2),
      .rx_done_tick (done2),
      .frame_err    (ferr2)
   );

   always #5 clk = ~clk;

   // dvsr=32: one os_tick every 2 clk; freezes while tick_en is low.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tick_en) os_tick <= ~os_tick;
      else         os_tick <= 1'b0;
   end

   // Record every strobe away from the active edge.
   always @(negedge clk) begin
      if (done) begin
         got_q.push_back(dout);
         last_done_cyc = cyc;
      end
      if (ferr) ferr_cnt++;
      if (done && ferr) both_cnt++;
      if (done2) got2_q.push_back({1'b0, dout2});
      if (ferr2) ferr2_cnt++;
      if (done2 && ferr2) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rx = v;
      else          rx2 = v;
   endtask

   // Drive one frame at 32 clk per bit. stall_bit stretches that data bit by 100 clk
   // with ticks frozen; abort_bit pulses reset mid-bit and releases the line.
   task automatic send_frame(input int sel, input logic [7:0] data, input int dbits,
                             input int sbt, input logic stop_val,
                             input int stall_bit, input int abort_bit);
      set_line(sel, 1'b0);
      clks(32);
      for (int i = 0; i < dbits; i++) begin
         set_line(sel, data[i]);
         if (i == abort_bit) begin
            clks(16);
            rst = 1'b1;
            set_line(sel, 1'b1);
            clks(1);
            rst = 1'b0;
            return;
         end
         if (i == stall_bit) begin
            clks(8);
            tick_en = 1'b0;
            clks(100);
            tick_en = 1'b1;
            clks(24);
         end else begin
            clks(32);
         end
      end
      set_line(sel, stop_val);
      clks(sbt * 2);
      set_line(sel, 1'b1);
   endtask

   // Model: a good frame yields its data bits, masked to the word width.
   task automatic good_frame(input int sel, input logic [7:0] data, input int dbits, input int sbt);
      logic [7:0] m;
      m = data & 8'((1 << dbits) - 1);
      send_frame(sel, data, dbits, sbt, 1'b1, -1, -1);
      if (sel == 0) begin exp_q.push_back(m);  exp_dout  = m; end
      else          begin exp2_q.push_back(m); exp_dout2 = m; end
   endtask

   task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$],
                        inout int idx);
      int n;
      check({tag, "_count"}, got.size(), exp.size());
      n = (got.size() < exp.size()) ? got.size() : exp.size();
      for (int i = idx; i < n; i++) begin
         check($sformatf("%s_word%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
      end
      idx = n;
   endtask

   initial begin
      int f0, e0, lat, w;
      logic [7:0] r;

      rst = 1'b1; rx = 1'b1; rx2 = 1'b1; tick_en = 1'b1;
      exp_dout = 8'h00; exp_dout2 = 8'h00;
      clks(4);
      rst = 1'b0;
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ferr", {31'd0, ferr}, 32'd0);
      check("rst_dout2", {25'd0, dout2}, 32'd0);
      clks(10);

      // Single 8N1 frame with latency bound of ~9.5 bit times.
      e0 = cyc;
      good_frame(0, 8'hA5, 8, 16);
      clks(40);
      lat = last_done_cyc - e0;
      cmp_q("a5", got_q, exp_q, idx1);
      check("a5_ferr", ferr_cnt, 0);
      check("a5_latency_ok", {31'd0, (lat >= 300 && lat <= 315)}, 32'd1);
      check("a5_dout", {24'd0, dout}, {24'd0, exp_dout});

      // Short low glitches are rejected at the mid-start check.
      for (int k = 0; k < 3; k++) begin
         w = (k == 0) ? 4 : $urandom_range(1, 6);
         rx = 1'b0;
         clks(2 * w);
         rx = 1'b1;
         clks(64);
      end
      cmp_q("glitch", got_q, exp_q, idx1);
      check("glitch_ferr", ferr_cnt, 0);
      check("glitch_dout", {24'd0, dout}, {24'd0, exp_dout});

      // Framing error followed by a long break; one strobe only.
      send_frame(0, 8'h3C, 8, 16, 1'b0, -1, -1);
      rx = 1'b0;
      clks(640);
      check("brk_ferr", ferr_cnt, 1);
      cmp_q("brk", got_q, exp_q, idx1);
      check("brk_dout", {24'd0, dout}, {24'd0, exp_dout});
      rx = 1'b1;
      clks(64);
      check("brk_release_ferr", ferr_cnt, 1);
      good_frame(0, 8'h5A, 8, 16);
      clks(40);
      cmp_q("after_brk", got_q, exp_q, idx1);

      // Back-to-back frames, no idle bits.
      good_frame(0, 8'h00, 8, 16);
      good_frame(0, 8'hFF, 8, 16);
      good_frame(0, 8'h81, 8, 16);
      clks(40);
      cmp_q("b2b", got_q, exp_q, idx1);
      check("b2b_ferr", ferr_cnt, 1);
      check("b2b_dout", {24'd0, dout}, {24'd0, exp_dout});

      // 7 data bits, 2 stop bits, back-to-back.
      good_frame(1, 8'h7F, 7, 32);
      good_frame(1, 8'($urandom), 7, 32);
      good_frame(1, 8'($urandom), 7, 32);
      clks(60);
      cmp_q("d7s2", got2_q, exp2_q, idx2);
      check("d7s2_ferr", ferr2_cnt, 0);
      check("d7s2_dout", {25'd0, dout2}, {24'd0, exp_dout2});

      // Reset during data bit 4 aborts the frame silently.
      f0 = ferr_cnt;
      r = 8'($urandom);
      send_frame(0, r, 8, 16, 1'b1, -1, 4);
      exp_dout = 8'h00; exp_dout2 = 8'h00;
      check("abort_dout", {24'd0, dout}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_ferr", {31'd0, ferr}, 32'd0);
      check("abort_dout2", {25'd0, dout2}, 32'd0);
      clks(400);
      cmp_q("abort", got_q, exp_q, idx1);
      good_frame(0, 8'h11, 8, 16);
      clks(40);
      cmp_q("after_abort", got_q, exp_q, idx1);
      check("abort_ferr_cnt", ferr_cnt - f0, 0);

      // os_tick stalled 100 clk mid-DATA.
      r = 8'($urandom);
      send_frame(0, r, 8, 16, 1'b1, $urandom_range(0, 7), -1);
      exp_q.push_back(r); exp_dout = r;
      clks(40);
      cmp_q("stall", got_q, exp_q, idx1);
      check("stall_dout", {24'd0, dout}, {24'd0, exp_dout});

      // Random bytes with random idle gaps (including none).
      for (int k = 0; k < 6; k++) begin
         good_frame(0, 8'($urandom), 8, 16);
         clks($urandom_range(0, 40));
      end
      clks(40);
      cmp_q("rand", got_q, exp_q, idx1);
      check("rand_dout", {24'd0, dout}, {24'd0, exp_dout});
      check("rand_ferr", ferr_cnt - f0, 0);
      check("strobe_overlap", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive deserializer for the UART core. Consumes the 16x oversampling tick from the baud generator, detects and validates the start bit, mid-bit samples DBITS data bits LSB-first, checks the stop bit, and presents the received byte with a one-cycle done strobe or a framing-error strobe. It sits between the raw serial pin and the receive FIFO or host logic.

## Interface

- DBITS, 8, data bits per frame (5..8)
- SB_TICKS, 16, oversampling ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- rx  input  1  serial input, asynchronous to clk, idle high
- os_tick  input  1  oversampling tick, one clk wide, 16 per bit period
- dout  output  DBITS  last correctly received word, held until next good frame
- rx_done_tick  output  1  one-clk pulse: new word valid on dout
- frame_err  output  1  one-clk pulse: stop bit sampled low

## Operation

- rx passes through a 2-FF synchronizer, both stages reset to 1. All decisions use the synchronized value rx_s.
- Internal: tick counter s (4 bits min, wide enough for SB_TICKS-1), bit counter n (3 bits), shift register b (DBITS).
- IDLE: on rx_s==0 -> START, s<=0. os_tick not required to leave IDLE.
- START: on os_tick, if s==7: rx_s==0 -> DATA, s<=0, n<=0; rx_s==1 -> IDLE (glitch rejected, no strobe). Otherwise s<=s+1.
- DATA: on os_tick, if s==15: s<=0, b<={rx_s, b[DBITS-1:1]}. If n==DBITS-1 -> STOP, else n<=n+1. Otherwise s<=s+1. Samples fall mid-bit.
- STOP: on os_tick, if s==SB_TICKS-1: rx_s==1 -> dout<=b, rx_done_tick pulse, -> IDLE; rx_s==0 -> frame_err pulse, dout unchanged, -> BRK. Otherwise s<=s+1.
- BRK: line held low (break or misframe). Stay until rx_s==1, then -> IDLE. Prevents a held-low line from being re-decoded as frames of 0x00.
- Without os_tick, the state and counters freeze in START, DATA and STOP. No timeout.
- rx_done_tick and frame_err are mutually exclusive. Neither fires outside STOP.

## Timing

- Reset values: state IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, synchronizer=1.
- Reset asserted mid-frame aborts the frame. No strobe is issued. The partial word is discarded. After release, the receiver waits in IDLE for the next falling edge.
- Synchronizer latency is 2 clk from a rx edge to rx_s.
- Strobes and dout are registered. They update on the clk edge that consumes the final stop-bit os_tick and are visible the following cycle for exactly one cycle. dout changes on that same edge.
- Frame length from start edge to strobe: 8 + 16*DBITS + SB_TICKS os_ticks, plus 2-3 clk of synchronizer and edge-detect skew.
- The receiver is ready for a new start edge in the cycle after the strobe. Back-to-back frames with zero idle time must be received.

## Structure

- Shared UART package/header: state encodings (IDLE, START, DATA, STOP, BRK), OS_RATE=16, mid-bit constant 7. The transmitter reuses these.
- One sub-module, sync2: a 2-flop synchronizer with a reset value parameter. The FSM and datapath stay in uart_rx.

## Test plan

- Use dvsr=32 (os_tick every 2 clk, bit = 32 clk) for all scenarios.
- Send 0xA5, 8N1 -> dout=0xA5, one rx_done_tick, frame_err=0 throughout, pulse about 9.5 bit times after the start edge.
- Pulse rx low for 4 os_ticks, then high -> FSM returns to IDLE. No strobe. dout unchanged.
- Send 0x3C with the stop bit forced low, then hold rx low for 20 bit times -> exactly one frame_err, dout keeps the previous value, no further strobes until rx returns high. Then send 0x5A -> received correctly.
- Send 0x00, 0xFF, 0x81 back-to-back with no idle bits -> three rx_done_ticks carrying values in order. Repeat with SB_TICKS=32 and DBITS=7 (0x7F).
- Assert rst for 1 clk during bit 4 of a frame -> all outputs 0 the next cycle. No strobe for the aborted frame. The next full frame 0x11 is received correctly.
- Stall os_tick for 100 clk mid-DATA, then resume -> byte is still received correctly.
